// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multicycle RV32I control FSM:
//               state codes, RV32I opcodes, ALUOp codes and datapath mux
//               select codes, plus the decode-stage dispatch function.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  // Control FSM state codes (4 bits)
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_LUI      = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_ALUWB    = 4'd12,
    S_BEQ      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // RV32I opcodes (instr[6:0])
  localparam logic [6:0] C_OP_LW   = 7'b0000011;
  localparam logic [6:0] C_OP_SW   = 7'b0100011;
  localparam logic [6:0] C_OP_R    = 7'b0110011;
  localparam logic [6:0] C_OP_I    = 7'b0010011;
  localparam logic [6:0] C_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] C_OP_JAL  = 7'b1101111;
  localparam logic [6:0] C_OP_JALR = 7'b1100111;
  localparam logic [6:0] C_OP_LUI  = 7'b0110111;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] C_ALUOP_LUI   = 2'b11;

  // Result mux select
  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] C_SRCA_PC    = 2'b00;
  localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] C_SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] C_SRCB_RS2  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  // Decode-stage dispatch: first execution state for a given opcode.
  // Unknown opcodes land in the absorbing trap state.
  function automatic state_t decode_dispatch(input logic [6:0] opcode);
    state_t st;
    case (opcode)
      C_OP_LW, C_OP_SW: st = S_MEMADR;
      C_OP_R:           st = S_EXECR;
      C_OP_I:           st = S_EXECI;
      C_OP_BEQ:         st = S_BEQ;
      C_OP_JAL:         st = S_JAL;
      C_OP_JALR:        st = S_JALR;
      C_OP_LUI:         st = S_LUI;
      default:          st = S_TRAP;
    endcase
    return st;
  endfunction

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multicycle RV32I datapath.
//               Sequences fetch/decode/execute/memory/write-back and drives
//               every datapath mux and enable. Stalls in the memory states
//               on a request/ready handshake with the shared memory.
// Revision    : 1.0 - initial release
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_opcode      in   instr[6:0] from the instruction register
//   i_zero        in   ALU zero flag (same cycle)
//   i_mem_ready   in   memory completed the current access this cycle
//   o_mem_req     out  memory access request, held until ready
//   o_mem_write   out  write strobe, valid only with o_mem_req
//   o_adr_src     out  memory address: 0 = PC, 1 = ALUOut
//   o_ir_write    out  load IR and OldPC
//   o_pc_write    out  PC load enable
//   o_reg_write   out  register file write enable
//   o_result_src  out  00 ALUOut, 01 Data, 10 ALUResult
//   o_alu_src_a   out  00 PC, 01 OldPC, 10 rs1
//   o_alu_src_b   out  00 rs2, 01 ImmExt, 10 constant 4
//   o_alu_op      out  00 add, 01 sub, 10 R-type decode, 11 LUI pass
//   o_instr_done  out  one-cycle pulse when an instruction retires
//   o_illegal     out  high while trapped on an illegal opcode
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_instr_done,
  output logic       o_illegal
);

  state_t r_state;
  state_t w_next_state;
  logic   w_pc_update;
  logic   w_branch;

  // State register; async reset forces all outputs low immediately,
  // including in the middle of a pending memory access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET:    w_next_state = S_FETCH;
      S_FETCH:    if (i_mem_ready) w_next_state = S_DECODE;
      S_DECODE:   w_next_state = decode_dispatch(i_opcode);
      // Only lw/sw reach here; anything not a store is treated as a load.
      S_MEMADR:   w_next_state = (i_opcode == C_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (i_mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (i_mem_ready) w_next_state = S_FETCH;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_LUI:      w_next_state = S_ALUWB;
      S_JALR:     w_next_state = S_JAL;
      S_JAL:      w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_RESET;
    endcase
  end

  // Output decode
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_result_src = C_RES_ALUOUT;
    o_alu_src_a  = C_SRCA_PC;
    o_alu_src_b  = C_SRCB_RS2;
    o_alu_op     = C_ALUOP_ADD;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = C_SRCB_FOUR;
        o_result_src = C_RES_ALURESULT;
        // IR and PC+4 are committed only in the cycle the read completes.
        o_ir_write   = i_mem_ready;
        w_pc_update  = i_mem_ready;
      end
      S_DECODE: begin
        // Precompute OldPC+imm as the branch/JAL target into ALUOut.
        o_alu_src_a = C_SRCA_OLDPC;
        o_alu_src_b = C_SRCB_IMM;
      end
      S_MEMADR: begin
        o_alu_src_a = C_SRCA_RS1;
        o_alu_src_b = C_SRCB_IMM;
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = C_RES_DATA;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        o_mem_req    = 1'b1;
        o_mem_write  = 1'b1;
        o_adr_src    = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_EXECR: begin
        o_alu_src_a = C_SRCA_RS1;
        o_alu_op    = C_ALUOP_RTYPE;
      end
      S_EXECI: begin
        o_alu_src_a = C_SRCA_RS1;
        o_alu_src_b = C_SRCB_IMM;
        o_alu_op    = C_ALUOP_RTYPE;
      end
      S_LUI: begin
        o_alu_src_b = C_SRCB_IMM;
        o_alu_op    = C_ALUOP_LUI;
      end
      S_JALR: begin
        // rs1+imm overwrites the target held in ALUOut; S_JAL then uses it.
        o_alu_src_a = C_SRCA_RS1;
        o_alu_src_b = C_SRCB_IMM;
      end
      S_JAL: begin
        // PC loads the target from ALUOut while the ALU forms the link
        // address OldPC+4 for the following write-back.
        o_alu_src_a  = C_SRCA_OLDPC;
        o_alu_src_b  = C_SRCB_FOUR;
        o_result_src = C_RES_ALUOUT;
        w_pc_update  = 1'b1;
      end
      S_ALUWB: begin
        o_result_src = C_RES_ALUOUT;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a  = C_SRCA_RS1;
        o_alu_op     = C_ALUOP_SUB;
        o_result_src = C_RES_ALUOUT;
        w_branch     = 1'b1;
        o_instr_done = 1'b1;
      end
      S_TRAP: begin
        o_illegal = 1'b1;
      end
      default: begin
      end
    endcase
    // Branch decision depends on the same-cycle zero flag.
    o_pc_write = w_pc_update | (w_branch & i_zero);
  end

endmodule : multicycle_control
`default_nettype wire
